// File: rtl/inject_arbiter_pkg.sv
// Shared types for the injection arbiter: FSM state encoding.
package PhiversPkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_SIZE,
        ST_PAYLOAD
    } inject_arb_state_t;

endpackage

// File: rtl/inject_arbiter_rr_arbiter.sv
// Round-robin request arbiter with a registered last-served pointer;
// the pointer only moves when update_i is pulsed at packet completion.
module rr_arbiter #(
    parameter int N_SRC = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [N_SRC-1:0]                       req_i,
    input  logic                                   update_i,
    input  logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] served_i,
    output logic [N_SRC-1:0]                       grant_o
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [IDX_W-1:0] last_q;
    int               idx;
    logic             found;

    // Pointer resets to the highest source so that source 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= IDX_W'(N_SRC - 1);
        end else if (update_i) begin
            last_q <= served_i;
        end
    end

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(last_q) + k) % N_SRC;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inject_arbiter.sv
// Packet-granular arbiter merging N_SRC injectors onto one NoC input port.
// Define INJECT_ARBITER_MA_PRIORITY_EN for fixed priority to source 0.
module inject_arbiter
    import PhiversPkg::*;
#(
    parameter int FLIT_SIZE = 32,
    parameter int N_SRC     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_SRC-1:0]             src_rx_i,
    input  logic [N_SRC*FLIT_SIZE-1:0]   src_data_i,
    output logic [N_SRC-1:0]             src_credit_o,
    output logic                         tx_o,
    output logic [FLIT_SIZE-1:0]         data_o,
    input  logic                         credit_i,
    output logic [N_SRC-1:0]             grant_o,
    output logic                         busy_o
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    inject_arb_state_t    state_q, state_d;
    logic [N_SRC-1:0]     grant_q, grant_d;
    logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     owner;
    logic [FLIT_SIZE-1:0] owner_data;
    logic [N_SRC-1:0]     winner;
    logic                 busy;
    logic                 xfer;
    logic                 pkt_done;

    always_comb begin
        owner = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) owner = IDX_W'(i);
        end
    end

    assign owner_data = src_data_i[int'(owner)*FLIT_SIZE +: FLIT_SIZE];
    assign busy       = (state_q != ST_IDLE);
    assign xfer       = busy && src_rx_i[owner] && credit_i;

`ifdef INJECT_ARBITER_MA_PRIORITY_EN
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_rx_i[i]) winner = N_SRC'(1) << i;
        end
    end
`else
    rr_arbiter #(
        .N_SRC (N_SRC)
    ) u_rr_arbiter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (src_rx_i),
        .update_i (pkt_done),
        .served_i (owner),
        .grant_o  (winner)
    );
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        pkt_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|src_rx_i) begin
                    grant_d = winner;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (xfer) state_d = ST_SIZE;
            end
            ST_SIZE: begin
                if (xfer) begin
                    cnt_d = owner_data;
                    if (owner_data == '0) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        pkt_done = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == FLIT_SIZE'(1)) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        pkt_done = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Data path is purely combinational toward the current owner.
    always_comb begin
        src_credit_o = '0;
        tx_o         = 1'b0;
        data_o       = '0;
        if (busy) begin
            tx_o                = src_rx_i[owner];
            data_o              = owner_data;
            src_credit_o[owner] = credit_i;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy;

endmodule

// File: doc/inject_arbiter.md
INJECT_ARBITER -- requirements
Module: inject_arbiter

Interface
REQ-001 Parameter FLIT_SIZE, default 32: width of every data flit and of the size field.
REQ-002 Parameter N_SRC, default 2: number of injector sources; fixed at 2 in this release.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 src_rx_i  input  N_SRC  per-source flit-valid.
REQ-006 src_data_i  input  N_SRC x FLIT_SIZE  per-source flit data; index 0 is management, index 1 is application.
REQ-007 src_credit_o  output  N_SRC  per-source credit back to the injector.
REQ-008 tx_o  output  1  flit-valid toward the shared local NoC input port.
REQ-009 data_o  output  FLIT_SIZE  flit data toward the NoC.
REQ-010 credit_i  input  1  NoC credit; a flit transfers in any cycle where tx_o=1 and credit_i=1.
REQ-011 grant_o  output  N_SRC  one-hot current owner; all zeros when idle.
REQ-012 busy_o  output  1  high while a packet is owned.

Function
REQ-013 Packet format: flit 0 is the header, flit 1 is the payload size S (unsigned FLIT_SIZE), then S payload flits.
REQ-014 Packet length is S+2 flits; S=0 is legal.
REQ-015 Arbitration is packet-granular; ownership never changes inside a packet.
REQ-016 FSM states: IDLE, HEADER, SIZE, PAYLOAD.
REQ-017 IDLE: if any src_rx_i=1, register the winner into grant and go to HEADER next cycle. This is a 1-cycle arbitration bubble; no flit transfers in IDLE.
REQ-018 HEADER: on transfer, go to SIZE.
REQ-019 SIZE: on transfer, latch S into the remaining-flit counter. If S=0, go to IDLE; otherwise go to PAYLOAD.
REQ-020 PAYLOAD: the counter decrements on each transfer. On the transfer taken with counter=1, go to IDLE and clear grant.
REQ-021 While granted, the data path is combinational: tx_o=src_rx_i[g], data_o=src_data_i[g], src_credit_o[g]=credit_i, and all other src_credit_o are 0.
REQ-022 Arbitration is round-robin. The last-served pointer updates when a packet completes, and the other source wins when both request.
REQ-023 Stalls: if src_rx_i[g]=0 or credit_i=0, the state and counter hold; there is no timeout.
REQ-024 When not granted: tx_o=0, data_o=0, src_credit_o=0.
REQ-025 The counter is FLIT_SIZE bits wide, with no wrap; S=2^FLIT_SIZE-1 is legal.
REQ-026 busy_o is 1 in HEADER, SIZE and PAYLOAD, and 0 in IDLE.

Reset
REQ-027 While rst_ni=0 at a clock edge: state=IDLE, grant=0, counter=0, and the round-robin pointer points at source 1, so source 0 wins the first tie.
REQ-028 Output values in reset: tx_o=0, data_o=0, src_credit_o=0, grant_o=0, busy_o=0.
REQ-029 Reset mid-packet abandons the packet. Its remaining flits are not forwarded, and the injectors are reset by the same rst_ni.

Configuration
REQ-030 Macro INJECT_ARBITER_MA_PRIORITY_EN defined: source 0 wins every IDLE tie; the pointer is unused. Starvation of source 1 is accepted.
REQ-031 Macro undefined: round-robin per REQ-022.

Structure
REQ-032 Package PhiversPkg holds the FSM state enum (inject_arb_state_t).
REQ-033 Widths are derived from FLIT_SIZE; there are no new package constants.
REQ-034 One sub-module, rr_arbiter: N_SRC-wide round-robin grant with registered pointer and update-enable; single flat module otherwise.

Verification
REQ-035 Source 0 alone sends header 0x0000_0101, S=3, payload 0xA,0xB,0xC with credit_i=1.
  - Exactly 5 flits appear in order on data_o.
  - grant_o=01 from the cycle after rx.
  - Back to IDLE after the 5th transfer.
REQ-036 Both sources request in the same cycle after reset, each with S=2.
  - Source 0 packet is forwarded completely, then a 1-cycle bubble, then source 1 packet.
  - Flits are never interleaved.
REQ-037 Source 1 sends S=0.
  - 2 flits are forwarded, then IDLE.
  - busy_o falls the cycle after the size flit transfers.
REQ-038 credit_i=0 for 4 cycles during PAYLOAD of an S=4 packet.
  - src_credit_o[g]=0 during the stall and no transfers occur.
  - Counter holds; completion happens after exactly 4 more credited transfers.
REQ-039 rst_ni=0 asserted during PAYLOAD.
  - The next cycle shows all outputs 0 and state IDLE.
  - A new source 0 packet then transfers correctly.
REQ-040 With INJECT_ARBITER_MA_PRIORITY_EN defined and both sources continuously requesting, source 0 is granted for 3 consecutive packets.
